// File: rtl/conv_window_generator.sv
// ----------------------------------------------------------------------------
// conv_window_generator
//
// Front end of the 3x3 multi-channel FP32 convolution block. Takes a
// raster-order pixel stream (one pixel per beat, all channels side by side),
// keeps the two previous rows in line buffers and slides a 3x3 window across
// the image. For every output position that needs no padding it presents one
// complete window per channel on a valid/ready interface. Sample bits are
// passed through untouched.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   valid_in     input pixel valid
//   ready_in     block can accept a pixel this cycle
//   data_in      pixel, all channels [CHANNELS-1:0][DATA_WIDTH-1:0]
//   valid_out    window valid
//   ready_out    consumer accepts the window
//   window_out   window per channel, row-major, element index i*3+j
//   window_last  set with the final window of a frame (qualified by valid_out)
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
// ----------------------------------------------------------------------------
module conv_window_generator #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 1,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       valid_in,
    output logic                                                       ready_in,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]                        data_in,
    output logic                                                       valid_out,
    input  logic                                                       ready_out,
    output logic [CHANNELS-1:0][KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_out,
    output logic                                                       window_last,
    output logic                                                       frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] FIRST_COL = COL_W'(2);
    localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(2);

    typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] pixel_t;
    // One window column; element 0 is the top (oldest) row.
    typedef pixel_t [2:0] column_t;

    // The window and line-buffer structure below is hard-wired for 3x3.
    generate
        if (KERNEL_SIZE != 3) begin : gKernelCheck
            $error("conv_window_generator: only KERNEL_SIZE == 3 is supported");
        end
        if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : gImageCheck
            $error("conv_window_generator: IMG_WIDTH and IMG_HEIGHT must be >= 3");
        end
    endgenerate

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             validOut_q, validOut_d;
    logic             windowLast_q, windowLast_d;
    logic             frameDone_q, frameDone_d;

    pixel_t           lineBuf0_q [IMG_WIDTH];
    pixel_t           lineBuf1_q [IMG_WIDTH];
    column_t [2:0]    window_q;
    column_t          newColumn;

    logic             accept;
    logic             emit;
    logic             atLastCol;
    logic             atLastRow;

    // No skid buffer: a pending window blocks input until the consumer takes it,
    // which is what keeps the held window stable during a stall.
    assign ready_in  = !validOut_q || ready_out;
    assign accept    = valid_in && ready_in;
    assign atLastCol = (col_q == LAST_COL);
    assign atLastRow = (row_q == LAST_ROW);
    assign emit      = (row_q >= FIRST_ROW) && (col_q >= FIRST_COL);

    // Column entering the window: two rows up, one row up, then the new pixel.
    assign newColumn = {data_in, lineBuf1_q[col_q], lineBuf0_q[col_q]};

    // Position counters and output flags. An accepted pixel decides the next
    // window state outright; without an accept, a handshake retires the window.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        validOut_d   = validOut_q;
        windowLast_d = windowLast_q;
        frameDone_d  = 1'b0;
        if (accept) begin
            if (atLastCol) begin
                col_d = '0;
                row_d = atLastRow ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            validOut_d   = emit;
            windowLast_d = emit && atLastRow && atLastCol;
            frameDone_d  = atLastRow && atLastCol;
        end else if (ready_out) begin
            validOut_d   = 1'b0;
            windowLast_d = 1'b0;
        end
    end

    // Control state register; only this part is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            validOut_q   <= 1'b0;
            windowLast_q <= 1'b0;
            frameDone_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            validOut_q   <= validOut_d;
            windowLast_q <= windowLast_d;
            frameDone_q  <= frameDone_d;
        end
    end

    // Data path: line buffers age by one row at this column and the window
    // shifts left by one column. Contents need no reset because emission only
    // happens once two fresh rows of the current frame have been written.
    always_ff @(posedge clk) begin
        if (accept) begin
            lineBuf0_q[col_q] <= lineBuf1_q[col_q];
            lineBuf1_q[col_q] <= data_in;
            window_q          <= {newColumn, window_q[2], window_q[1]};
        end
    end

    // Reorder the column-major window register into row-major per-channel output.
    always_comb begin
        window_out = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    window_out[ch][i*3+j] = window_q[j][i][ch];
                end
            end
        end
    end

    assign valid_out   = validOut_q;
    assign window_last = windowLast_q;
    assign frame_done  = frameDone_q;

endmodule

// File: tb/tb_conv_window_generator.sv
// ----------------------------------------------------------------------------
// tb_conv_window_generator
//
// Drives 4x4 two-channel frames through conv_window_generator. Pixel (r,c) of
// a frame with offset B carries value B + r*4 + c on channel 0 and that value
// + 0x40000000 on channel 1, so window element i*3+j at top-left value T is
// T + i*4 + j on channel 0.
// ----------------------------------------------------------------------------
module tb_conv_window_generator;

    localparam int DW = 32;
    localparam int CH = 2;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int KK = 9;
    localparam logic [31:0] CH1_OFS = 32'h4000_0000;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      valid_in;
    logic                      ready_in;
    logic [CH-1:0][DW-1:0]     data_in;
    logic                      valid_out;
    logic                      ready_out;
    logic [CH-1:0][KK-1:0][DW-1:0] window_out;
    logic                      window_last;
    logic                      frame_done;

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;

    typedef struct {
        logic        vin;
        logic        rout;
        logic [31:0] pix;
        logic        expReady;
        logic        expValid;
        logic        expLast;
        logic        expDone;
        int          expTl;
    } vec_t;

    typedef struct {
        logic [KK-1:0][DW-1:0] c0;
        logic [KK-1:0][DW-1:0] c1;
        logic                  last;
    } cap_t;

    vec_t vecs[$];
    cap_t capQ[$];

    always #5 clk = ~clk;

    conv_window_generator #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(3),
        .CHANNELS   (CH),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .window_out (window_out),
        .window_last(window_last),
        .frame_done (frame_done)
    );

    // Record every window that is handed over and count frame_done pulses.
    always begin
        cap_t c;
        @(negedge clk);
        #2;
        if (valid_out && ready_out) begin
            c.c0   = window_out[0];
            c.c1   = window_out[1];
            c.last = window_last;
            capQ.push_back(c);
        end
        if (frame_done) doneCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vin, input logic rout, input logic [31:0] pix);
        @(negedge clk);
        valid_in   = vin;
        ready_out  = rout;
        data_in[0] = pix;
        data_in[1] = pix + CH1_OFS;
    endtask

    task automatic checkWindowAt(input string name, input int tl);
        for (int e = 0; e < KK; e++) begin
            checkOutput({name, "_ch0"}, window_out[0][e], 32'(tl + (e / 3) * 4 + (e % 3)));
            checkOutput({name, "_ch1"}, window_out[1][e], 32'(tl + (e / 3) * 4 + (e % 3)) + CH1_OFS);
        end
    endtask

    // Reset with output checks; clears the capture log afterwards.
    task automatic applyReset();
        @(negedge clk);
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstReadyIn", ready_in, 1);
        checkOutput("rstValidOut", valid_out, 0);
        checkOutput("rstWindowLast", window_last, 0);
        checkOutput("rstFrameDone", frame_done, 0);
        capQ.delete();
        doneCount = 0;
    endtask

    // Present one pixel (after 'gap' idle cycles) and hold it until accepted.
    task automatic sendPixel(input logic [31:0] pix, input int gap);
        int guard;
        repeat (gap) applyStimulus(1'b0, ready_out, 32'd0);
        applyStimulus(1'b1, ready_out, pix);
        #1;
        guard = 0;
        while (!ready_in && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!ready_in) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout actual=ready_in0 required=ready_in1 pix=%0d", pix);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, 32'd0);
    endtask

    task automatic checkWindows(input string tag, input int expTl[$], input int expDone);
        int n;
        checkOutput({tag, "_count"}, capQ.size(), expTl.size());
        n = (capQ.size() < expTl.size()) ? capQ.size() : expTl.size();
        for (int k = 0; k < n; k++) begin
            for (int e = 0; e < KK; e++) begin
                checkOutput({tag, "_ch0"}, capQ[k].c0[e], 32'(expTl[k] + (e / 3) * 4 + (e % 3)));
                checkOutput({tag, "_ch1"}, capQ[k].c1[e], 32'(expTl[k] + (e / 3) * 4 + (e % 3)) + CH1_OFS);
            end
            checkOutput({tag, "_last"}, capQ[k].last, (k % 4) == 3);
        end
        checkOutput({tag, "_frameDone"}, doneCount, expDone);
    endtask

    function automatic void addVec(input logic vin, input logic rout, input int pix,
                                   input logic er, input logic ev, input logic el,
                                   input logic ed, input int tl);
        vec_t v;
        v.vin = vin; v.rout = rout; v.pix = 32'(pix);
        v.expReady = er; v.expValid = ev; v.expLast = el; v.expDone = ed; v.expTl = tl;
        vecs.push_back(v);
    endfunction

    initial begin
        int expTl[$];
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        data_in   = '0;

        // Continuous 4x4 frame; outputs checked before each beat's edge.
        //     vin rout pix  rdy val last done tl
        addVec(1, 1,  0,   1, 0, 0, 0, 0);
        addVec(1, 1,  1,   1, 0, 0, 0, 0);
        addVec(1, 1,  2,   1, 0, 0, 0, 0);
        addVec(1, 1,  3,   1, 0, 0, 0, 0);
        addVec(1, 1,  4,   1, 0, 0, 0, 0);
        addVec(1, 1,  5,   1, 0, 0, 0, 0);
        addVec(1, 1,  6,   1, 0, 0, 0, 0);
        addVec(1, 1,  7,   1, 0, 0, 0, 0);
        addVec(1, 1,  8,   1, 0, 0, 0, 0);
        addVec(1, 1,  9,   1, 0, 0, 0, 0);
        addVec(1, 1, 10,   1, 0, 0, 0, 0);
        addVec(1, 1, 11,   1, 1, 0, 0, 0);
        addVec(1, 1, 12,   1, 1, 0, 0, 1);
        addVec(1, 1, 13,   1, 0, 0, 0, 0);
        addVec(1, 1, 14,   1, 0, 0, 0, 0);
        addVec(1, 1, 15,   1, 1, 0, 0, 4);
        addVec(0, 0,  0,   0, 1, 1, 1, 5);
        addVec(0, 0,  0,   0, 1, 1, 0, 5);
        addVec(0, 1,  0,   1, 1, 1, 0, 5);
        addVec(0, 1,  0,   1, 0, 0, 0, 0);

        applyReset();
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].vin, vecs[k].rout, vecs[k].pix);
            #1;
            checkOutput($sformatf("v%0d_readyIn", k), ready_in, vecs[k].expReady);
            checkOutput($sformatf("v%0d_validOut", k), valid_out, vecs[k].expValid);
            checkOutput($sformatf("v%0d_windowLast", k), window_last, vecs[k].expLast);
            checkOutput($sformatf("v%0d_frameDone", k), frame_done, vecs[k].expDone);
            if (vecs[k].expValid) checkWindowAt($sformatf("v%0d_win", k), vecs[k].expTl);
        end
        idle(2);
        expTl = '{0, 1, 4, 5};
        checkWindows("tableRun", expTl, 1);

        // Stall: consumer holds off for 5 cycles after the first window.
        applyReset();
        for (int p = 0; p <= 10; p++) sendPixel(32'(p), 0);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, 1'b0, 32'd11);
            #1;
            checkOutput("stallReadyIn", ready_in, 0);
            checkOutput("stallValidOut", valid_out, 1);
            checkWindowAt("stallWin", 0);
        end
        applyStimulus(1'b1, 1'b1, 32'd11);
        for (int p = 12; p <= 15; p++) sendPixel(32'(p), 0);
        idle(3);
        expTl = '{0, 1, 4, 5};
        checkWindows("stallRun", expTl, 1);

        // valid_in alternating with idle beats.
        applyReset();
        for (int p = 0; p < 16; p++) sendPixel(32'(p), 1);
        idle(3);
        expTl = '{0, 1, 4, 5};
        checkWindows("toggleRun", expTl, 1);

        // Reset mid-frame after pixel 6, then a fresh frame offset by 100.
        applyReset();
        for (int p = 0; p <= 6; p++) sendPixel(32'(p), 0);
        applyReset();
        for (int p = 0; p < 16; p++) sendPixel(32'(100 + p), 0);
        idle(3);
        expTl = '{100, 101, 104, 105};
        checkWindows("resetRun", expTl, 1);

        // Two frames back to back, second offset by 200.
        applyReset();
        for (int p = 0; p < 16; p++) sendPixel(32'(p), 0);
        for (int p = 0; p < 16; p++) sendPixel(32'(200 + p), 0);
        idle(3);
        expTl = '{0, 1, 4, 5, 200, 201, 204, 205};
        checkWindows("b2bRun", expTl, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/conv_window_generator.md
Name: conv_window_generator

Overview:
- Upstream stage of the 3x3 multi-channel FP32 convolution block.
- Accepts a raster-order pixel stream: one pixel per beat, with all CHANNELS carried in parallel.
- Uses two line buffers and a 3x3 shift window to emit one complete KERNEL_SIZE x KERNEL_SIZE window per channel for every valid (unpadded) output position.
- Output is a valid/ready handshake, so the slow multiply/accumulate consumer can stall the stream.

Parameters:
- DATA_WIDTH, 32, bit width of one sample (raw FP32 bits; never interpreted).
- KERNEL_SIZE, 3, window edge; only 3 is supported (elaboration error otherwise).
- CHANNELS, 1, number of channels per pixel.
- IMG_WIDTH, 8, pixels per row; must be >= 3.
- IMG_HEIGHT, 8, rows per frame; must be >= 3.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  input pixel valid.
- ready_in  out  1  block can accept a pixel this cycle.
- data_in  in  [CHANNELS-1:0][DATA_WIDTH-1:0]  pixel, all channels.
- valid_out  out  1  window valid.
- ready_out  in  1  consumer accepts window.
- window_out  out  [CHANNELS-1:0][KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  window, row-major; index i*3+j.
- window_last  out  1  qualifies valid_out; marks the final window of a frame.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Beat acceptance: a pixel is accepted when valid_in && ready_in.
- ready_in = !valid_out || ready_out (combinational; no skid buffer).
- Counters:
  - col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) point at the next pixel to accept.
  - Width is $clog2 of the limit.
  - On accept, col increments; at IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and frame_done pulses the next cycle.
- Line buffers: two row buffers of IMG_WIDTH entries, each CHANNELS*DATA_WIDTH wide.
  - On accept at column c, the pixel from 2 rows up, the pixel from 1 row up and the new pixel form the column shifted into the window.
  - Buffer c is then updated (buf1[c] -> buf0[c], new pixel -> buf1[c]).
- Window register: 3 columns x 3 rows x CHANNELS; shifts left by one column on every accept.
- Window emission: when the pixel at (r,c) with r>=2 and c>=2 is accepted:
  - valid_out goes high the next cycle.
  - window_out[ch][i*3+j] = pixel(r-2+i, c-2+j)[ch].
  - Latency is 1 cycle from accept.
- Window count: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame. No windows are emitted for r<2 or c<2; those positions only fill buffers.
- window_last = 1 with the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Hold rule: while valid_out && !ready_out, window_out, window_last and valid_out are held stable and ready_in=0.
- Output transitions:
  - valid_out drops the cycle after a handshake unless a new emitting pixel was accepted in the same cycle. That is permitted because ready_in=1 when ready_out=1, and the new window replaces the old one.
- Frame boundaries:
  - Back-to-back frames need no idle cycles.
  - Stale line-buffer contents from the previous frame are never emitted, because emission requires r>=2 of the new frame.
- Reset (sync, any time including mid-frame):
  - col=0, row=0, valid_out=0, window_last=0, frame_done=0, ready_in=1 the following cycle.
  - Line buffer and window contents are don't-care, not cleared.
  - Any partial frame is discarded; the next accepted pixel is (0,0).
- valid_in=0 cycles: no state change; window and counters are held.

Test Plan:
- 4x4 frame, CHANNELS=1, pixel value = r*4+c, ready_out=1, continuous valid_in:
  - The first window appears 1 cycle after accepting pixel 10, containing {0,1,2,4,5,6,8,9,10}.
  - Exactly 4 windows total; the last is {5,6,7,9,10,11,13,14,15} with window_last=1.
  - frame_done pulses once.
- Same frame with ready_out held 0 for 5 cycles after the first window:
  - ready_in=0 throughout; window_out is stable.
  - No pixel is lost; the remaining windows are identical to the no-stall run.
- valid_in toggling 1/0 every cycle: same 4 windows, same values, in the same order.
- Reset asserted after pixel 6 is accepted, then a fresh 4x4 frame with values +100:
  - No window is emitted before pixel 110.
  - The first window is {100,101,102,104,105,106,108,109,110}.
- Two back-to-back 4x4 frames:
  - 8 windows.
  - The second frame's first window contains only second-frame values.
- CHANNELS=2, channel1 = channel0 + 0x40000000: each window's ch1 entries equal ch0 entries + 0x40000000, index for index.
